seven_segment_scan_ctrl: RTL and testbench
==========================================

SEVEN_SEGMENT_SCAN_CTRL -- requirements
Module: seven_segment_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 25000: clocks each digit is driven (1 ms at 25 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 250: dead clocks between digits (anti-ghosting); legal range >= 1.
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_Digit0, input, 4 bits: ones digit value, binary.
REQ-006 The block SHALL have port i_Digit1, input, 4 bits: tens digit value, binary.
REQ-007 The block SHALL have port i_Load, input, 1 bit: capture i_Digit0/i_Digit1 into pending registers.
REQ-008 The block SHALL have port i_Blank_Leading_Zero, input, 1 bit: suppress digit 1 when its value is 0.
REQ-009 The block SHALL have port o_Binary_Num, output, 4 bits: value fed to the shared binary-to-7-segment decoder.
REQ-010 The block SHALL have port o_Digit_Sel, output, 2 bits: one-hot digit enable, active high; bit0 = digit 0, bit1 = digit 1.
REQ-011 The block SHALL have port o_Frame, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 The block SHALL implement the state sequence S_D0 -> S_GAP0 -> S_D1 -> S_GAP1 -> S_D0, repeating indefinitely.
REQ-013 The block SHALL hold each S_Dx state for exactly DWELL_CYCLES clocks and each S_GAPx state for exactly BLANK_CYCLES clocks, for a frame period of 2*(DWELL_CYCLES+BLANK_CYCLES) clocks.
REQ-014 The block SHALL use one phase counter of width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)); it counts up from 0, and on reaching limit-1 it returns to 0 in the same cycle the state advances.
REQ-015 On every clock edge with i_Load=1, the block SHALL copy i_Digit0/i_Digit1 into pending registers; if several loads occur within one frame, the last one wins.
REQ-016 On the clock edge that moves S_GAP1 -> S_D0, the block SHALL copy the pending registers (pre-edge values) into the active registers, together with i_Blank_Leading_Zero; a load on that same edge therefore commits at the following frame boundary.
REQ-017 Active registers SHALL change only at a frame boundary, so no digit ever shows a value from a different load than its partner (no tearing).
REQ-018 The block SHALL drive o_Digit_Sel = 01 in S_D0, 10 in S_D1, and 00 in S_GAP0 and S_GAP1.
REQ-019 In S_D1, if the committed blank flag = 1 and active digit 1 = 0, the block SHALL drive o_Digit_Sel = 00; phase timing SHALL be unchanged.
REQ-020 The block SHALL drive o_Binary_Num = active digit 0 in S_D0, active digit 1 in S_D1, and 0 in gap states.
REQ-021 Values 10-15 SHALL pass through unmodified.
REQ-022 o_Frame SHALL be a registered signal, high for exactly the first clock of S_D0 reached from S_GAP1; it SHALL be 0 in the first S_D0 after reset.
REQ-023 o_Digit_Sel and o_Binary_Num SHALL be decoded only from registered state; no combinational path SHALL exist from any input to any output.

Reset
REQ-024 While i_Reset=1 at a clock edge, the block SHALL set state = S_D0, counter = 0, pending and active digits = 0, committed blank flag = 0, and o_Frame = 0.
REQ-025 In the first cycle after reset, outputs SHALL be o_Digit_Sel = 01 and o_Binary_Num = 0.
REQ-026 Reset asserted mid-frame SHALL abort the current phase immediately and discard any pending load.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, frame = 12 clocks, cycle 0 = first cycle after reset)
REQ-027 The bench SHALL check free-run after reset with no load: cycles 0-3 sel=01, num=0; 4-5 sel=00; 6-9 sel=10; 10-11 sel=00; cycle 12 sel=01 and o_Frame=1; cycle 0 o_Frame=0.
REQ-028 The bench SHALL check mid-frame load: i_Load with 7/3 at cycle 5 -> outputs unchanged through cycle 11; cycles 12-15 num=7; cycles 18-21 num=3.
REQ-029 The bench SHALL check load on the boundary edge: i_Load with 5/2 at cycle 11 -> frame at 12 still shows 0/0; frame at 24 shows 5/2.
REQ-030 The bench SHALL check two loads in one frame: 1/1 at cycle 2, then 8/4 at cycle 7 -> frame at 12 shows 8/4.
REQ-031 The bench SHALL check leading-zero blanking: digits 6/0 with blank=1 -> cycles 18-21 sel=00, num=0; same digits with blank=0 -> sel=10.
REQ-032 The bench SHALL check reset mid-operation: i_Reset at cycle 19 while 7/3 is active -> next cycle sel=01, num=0, counter=0; the subsequent frame shows 0/0.

Source files
------------

// File: rtl/seven_segment_scan_ctrl.sv
// Two-digit multiplexed seven-segment scan controller with frame-aligned digit commit.
// Latency: outputs decode registered state only; loads appear at the next frame boundary after capture.
// Backpressure: none; i_Load is accepted on every clock and the last load in a frame wins.
module seven_segment_scan_ctrl #(
    parameter int DWELL_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Digit0,
    input  logic [3:0] i_Digit1,
    input  logic       i_Load,
    input  logic       i_Blank_Leading_Zero,
    output logic [3:0] o_Binary_Num,
    output logic [1:0] o_Digit_Sel,
    output logic       o_Frame
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_D0   = 2'd0,
        S_GAP0 = 2'd1,
        S_D1   = 2'd2,
        S_GAP1 = 2'd3
    } state_t;

    state_t           r_State;
    state_t           w_Next_State;
    logic [CNT_W-1:0] r_Count;
    logic             w_Phase_Done;
    logic             w_Boundary;

    logic [3:0]       r_Pend_Digit0;
    logic [3:0]       r_Pend_Digit1;
    logic [3:0]       r_Act_Digit0;
    logic [3:0]       r_Act_Digit1;
    logic             r_Act_Blank;
    logic             r_Frame;

    // Phase end detection and next-state selection for the fixed scan cycle.
    always_comb begin
        w_Phase_Done = 1'b0;
        w_Next_State = r_State;
        case (r_State)
            S_D0: begin
                w_Phase_Done = (r_Count == DWELL_LAST);
                if (w_Phase_Done) w_Next_State = S_GAP0;
            end
            S_GAP0: begin
                w_Phase_Done = (r_Count == BLANK_LAST);
                if (w_Phase_Done) w_Next_State = S_D1;
            end
            S_D1: begin
                w_Phase_Done = (r_Count == DWELL_LAST);
                if (w_Phase_Done) w_Next_State = S_GAP1;
            end
            default: begin
                w_Phase_Done = (r_Count == BLANK_LAST);
                if (w_Phase_Done) w_Next_State = S_D0;
            end
        endcase
    end

    // The GAP1 -> D0 edge is the only point where displayed digits may change.
    assign w_Boundary = (r_State == S_GAP1) && w_Phase_Done;

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= S_D0;
        end else begin
            r_State <= w_Next_State;
        end
    end

    // Shared phase counter; wraps to 0 on the same edge the state advances.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Count <= '0;
        end else if (w_Phase_Done) begin
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + CNT_W'(1);
        end
    end

    // Pending digits follow every load; reset discards anything not yet committed.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Pend_Digit0 <= 4'd0;
            r_Pend_Digit1 <= 4'd0;
        end else if (i_Load) begin
            r_Pend_Digit0 <= i_Digit0;
            r_Pend_Digit1 <= i_Digit1;
        end
    end

    // Commit both digits and the blank flag together at the frame boundary so digits never tear.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Act_Digit0 <= 4'd0;
            r_Act_Digit1 <= 4'd0;
            r_Act_Blank  <= 1'b0;
        end else if (w_Boundary) begin
            r_Act_Digit0 <= r_Pend_Digit0;
            r_Act_Digit1 <= r_Pend_Digit1;
            r_Act_Blank  <= i_Blank_Leading_Zero;
        end
    end

    // Frame pulse marks the first D0 cycle of each frame except the one following reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Frame <= 1'b0;
        end else begin
            r_Frame <= w_Boundary;
        end
    end

    // Output decode from registered state only; values 10-15 pass straight through.
    always_comb begin
        o_Digit_Sel  = 2'b00;
        o_Binary_Num = 4'd0;
        case (r_State)
            S_D0: begin
                o_Digit_Sel  = 2'b01;
                o_Binary_Num = r_Act_Digit0;
            end
            S_D1: begin
                o_Binary_Num = r_Act_Digit1;
                if (!(r_Act_Blank && (r_Act_Digit1 == 4'd0))) begin
                    o_Digit_Sel = 2'b10;
                end
            end
            default: begin
                o_Digit_Sel  = 2'b00;
                o_Binary_Num = 4'd0;
            end
        endcase
    end

    assign o_Frame = r_Frame;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for the scan controller: frame-level behavioural model plus directed literal checks.
// Model works in "cycles since reset" and frame arithmetic, independent of the RTL's FSM.
// Inputs change #1 after the rising edge; outputs are compared at the falling edge.
module tb_seven_segment_scan_ctrl;

    localparam int D = 4;
    localparam int B = 2;
    localparam int P = 2 * (D + B);

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic [3:0] i_Digit0 = 4'd0;
    logic [3:0] i_Digit1 = 4'd0;
    logic       i_Load = 1'b0;
    logic       i_Blank_Leading_Zero = 1'b0;
    logic [3:0] o_Binary_Num;
    logic [1:0] o_Digit_Sel;
    logic       o_Frame;

    int n_vec = 0;
    int n_bad = 0;

    seven_segment_scan_ctrl #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .i_Clk               (i_Clk),
        .i_Reset             (i_Reset),
        .i_Digit0            (i_Digit0),
        .i_Digit1            (i_Digit1),
        .i_Load              (i_Load),
        .i_Blank_Leading_Zero(i_Blank_Leading_Zero),
        .o_Binary_Num        (o_Binary_Num),
        .o_Digit_Sel         (o_Digit_Sel),
        .o_Frame             (o_Frame)
    );

    always #5 i_Clk = ~i_Clk;

    // Behavioural model state: cycle index since reset, pending/active values.
    int         m_t = 0;
    bit         m_valid = 1'b0;
    logic [3:0] m_p0 = 0, m_p1 = 0, m_a0 = 0, m_a1 = 0;
    logic       m_blank = 0;

    always @(posedge i_Clk) begin
        if (i_Reset) begin
            m_t = 0; m_p0 = 0; m_p1 = 0; m_a0 = 0; m_a1 = 0; m_blank = 0;
            m_valid = 1'b1;
        end else begin
            if (m_t % P == P - 1) begin
                m_a0 = m_p0; m_a1 = m_p1; m_blank = i_Blank_Leading_Zero;
            end
            if (i_Load) begin
                m_p0 = i_Digit0; m_p1 = i_Digit1;
            end
            m_t = m_t + 1;
        end
    end

    function automatic logic [6:0] model_out(int t);
        int ph;
        logic [1:0] sel;
        logic [3:0] num;
        logic       fr;
        ph  = t % P;
        sel = 2'b00;
        num = 4'd0;
        if (ph < D) begin
            sel = 2'b01; num = m_a0;
        end else if (ph >= D + B && ph < 2 * D + B) begin
            num = m_a1;
            sel = (m_blank && m_a1 == 4'd0) ? 2'b00 : 2'b10;
        end
        fr = (t >= P) && (ph == 0);
        return {fr, sel, num};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge i_Clk) begin
        logic [6:0] exp_v;
        if (m_valid) begin
            exp_v = model_out(m_t);
            n_vec++;
            if ({o_Frame, o_Digit_Sel, o_Binary_Num} !== exp_v) begin
                n_bad++;
                $display("FAIL model t=%0d: got frame=%b sel=%b num=%0d, want frame=%b sel=%b num=%0d",
                         m_t, o_Frame, o_Digit_Sel, o_Binary_Num, exp_v[6], exp_v[5:4], exp_v[3:0]);
            end
        end
    end

    task automatic do_reset();
        i_Reset = 1'b1;
        @(posedge i_Clk); #1;
        i_Reset = 1'b0;
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while (m_t != c && guard < 200) begin
            @(posedge i_Clk); #1;
            guard++;
        end
        if (m_t != c) begin
            n_vec++; n_bad++;
            $display("FAIL goto: at cycle %0d, wanted cycle %0d", m_t, c);
        end
    endtask

    task automatic load_at(input int c, input logic [3:0] d0, input logic [3:0] d1);
        goto(c);
        i_Digit0 = d0; i_Digit1 = d1; i_Load = 1'b1;
        @(posedge i_Clk); #1;
        i_Load = 1'b0;
    endtask

    // Hand-computed literal expectation at a given cycle.
    task automatic lit(input string name, input int c, input logic [1:0] sel,
                       input logic [3:0] num, input logic fr);
        goto(c);
        n_vec++;
        if (o_Digit_Sel !== sel || o_Binary_Num !== num || o_Frame !== fr) begin
            n_bad++;
            $display("FAIL %s c=%0d: got sel=%b num=%0d frame=%b, want sel=%b num=%0d frame=%b",
                     name, c, o_Digit_Sel, o_Binary_Num, o_Frame, sel, num, fr);
        end
    endtask

    initial begin
        repeat (2) @(posedge i_Clk);
        #1;

        // Free run with no load.
        do_reset();
        lit("reset_c0", 0, 2'b01, 4'd0, 1'b0);
        lit("free_c3", 3, 2'b01, 4'd0, 1'b0);
        lit("free_c4", 4, 2'b00, 4'd0, 1'b0);
        lit("free_c5", 5, 2'b00, 4'd0, 1'b0);
        lit("free_c6", 6, 2'b10, 4'd0, 1'b0);
        lit("free_c9", 9, 2'b10, 4'd0, 1'b0);
        lit("free_c10", 10, 2'b00, 4'd0, 1'b0);
        lit("free_c11", 11, 2'b00, 4'd0, 1'b0);
        lit("free_c12", 12, 2'b01, 4'd0, 1'b1);
        lit("free_c13", 13, 2'b01, 4'd0, 1'b0);

        // Mid-frame load.
        do_reset();
        load_at(5, 4'd7, 4'd3);
        lit("mid_c6", 6, 2'b10, 4'd0, 1'b0);
        lit("mid_c12", 12, 2'b01, 4'd7, 1'b1);
        lit("mid_c15", 15, 2'b01, 4'd7, 1'b0);
        lit("mid_c18", 18, 2'b10, 4'd3, 1'b0);
        lit("mid_c21", 21, 2'b10, 4'd3, 1'b0);

        // Load on the boundary edge commits one frame later.
        do_reset();
        load_at(11, 4'd5, 4'd2);
        lit("edge_c12", 12, 2'b01, 4'd0, 1'b1);
        lit("edge_c18", 18, 2'b10, 4'd0, 1'b0);
        lit("edge_c24", 24, 2'b01, 4'd5, 1'b1);
        lit("edge_c30", 30, 2'b10, 4'd2, 1'b0);

        // Two loads in one frame: last wins.
        do_reset();
        load_at(2, 4'd1, 4'd1);
        load_at(7, 4'd8, 4'd4);
        lit("two_c12", 12, 2'b01, 4'd8, 1'b1);
        lit("two_c18", 18, 2'b10, 4'd4, 1'b0);

        // Leading-zero blanking, then the same digits unblanked.
        do_reset();
        i_Blank_Leading_Zero = 1'b1;
        load_at(1, 4'd6, 4'd0);
        lit("blank_c12", 12, 2'b01, 4'd6, 1'b1);
        lit("blank_c18", 18, 2'b00, 4'd0, 1'b0);
        lit("blank_c21", 21, 2'b00, 4'd0, 1'b0);
        goto(22);
        i_Blank_Leading_Zero = 1'b0;
        lit("noblank_c30", 30, 2'b10, 4'd0, 1'b0);

        // Values above 9 pass through.
        do_reset();
        load_at(3, 4'd15, 4'd10);
        lit("hex_c12", 12, 2'b01, 4'd15, 1'b1);
        lit("hex_c18", 18, 2'b10, 4'd10, 1'b0);

        // Reset mid-operation while 7/3 is active, with a pending load to discard.
        do_reset();
        load_at(5, 4'd7, 4'd3);
        load_at(14, 4'd9, 4'd9);
        lit("rst_c18", 18, 2'b10, 4'd3, 1'b0);
        goto(19);
        do_reset();
        lit("rst_c0", 0, 2'b01, 4'd0, 1'b0);
        lit("rst_c3", 3, 2'b01, 4'd0, 1'b0);
        lit("rst_c4", 4, 2'b00, 4'd0, 1'b0);
        lit("rst_c12", 12, 2'b01, 4'd0, 1'b1);
        lit("rst_c18", 18, 2'b10, 4'd0, 1'b0);

        @(posedge i_Clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
